// File: rtl/ppam_pkg.sv
// ------------------------------------------------------------------
// ppam_pkg: shared types, row-keep mask and 4:2 compressor.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package ppam_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int PROD_W    = 2 * WIDTH_DEF;
  localparam int MAX_W     = 32;

  typedef struct packed {
    logic cout;
    logic carry;
    logic sum;
  } c42_t;

  // x1+x2+x3+x4+cin == sum + 2*(carry+cout); cout does not depend on cin.
  function automatic c42_t comp42(input logic x1, input logic x2, input logic x3,
                                  input logic x4, input logic cin);
    logic s1;
    c42_t r;
    s1      = x1 ^ x2 ^ x3;
    r.cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
    r.sum   = s1 ^ x4 ^ cin;
    r.carry = (s1 & x4) | (s1 & cin) | (x4 & cin);
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] perf_mask(input int unsigned start,
                                                 input int unsigned len,
                                                 input int unsigned width);
    logic [MAX_W-1:0] keep;
    int unsigned      stop;
    keep = '0;
    stop = start + len;
    for (int unsigned j = 0; j < MAX_W; j++) begin
      keep[j] = (j < width) && !((j >= start) && (j < stop));
    end
    return keep;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ppam_pp_reduce.sv
// ------------------------------------------------------------------
// ppam_pp_reduce: masked partial products to a carry-save pair.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ppam_pp_reduce
  import ppam_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   keep,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] carry
);

  localparam int PW_PROD = 2 * WIDTH;

  logic [WIDTH:0] w_sel;
  assign w_sel = {1'b0, keep & b};

  // Two rows folded into the running (sum, carry) pair per 4:2 level.
  always_comb begin
    logic [PW_PROD-1:0] s, c, r0, r1, ns, nc;
    c42_t               q;
    logic               ci;
    s  = '0;
    c  = '0;
    r0 = '0;
    r1 = '0;
    ns = '0;
    nc = '0;
    q  = '0;
    ci = 1'b0;
    for (int j = 0; j < WIDTH; j += 2) begin
      r0 = w_sel[j]     ? (PW_PROD'(a) << j)       : '0;
      r1 = w_sel[j + 1] ? (PW_PROD'(a) << (j + 1)) : '0;
      ci = 1'b0;
      for (int k = 0; k < PW_PROD; k++) begin
        q     = comp42(s[k], c[k], r0[k], r1[k], ci);
        ns[k] = q.sum;
        nc[k] = q.carry;
        ci    = q.cout;
      end
      s = ns;
      c = nc << 1;
    end
    sum   = s;
    carry = c;
  end

endmodule

`default_nettype wire

// File: rtl/ppam_mult_pipe.sv
// ------------------------------------------------------------------
// ppam_mult_pipe: 2-stage perforated multiplier, valid/ready; PPAM_ERR_EN adds err outputs.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ppam_mult_pipe
  import ppam_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PW    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [PW-1:0]      perf_start,
  input  logic [PW-1:0]      perf_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
`ifdef PPAM_ERR_EN
  ,
  input  logic               err_clr,
  output logic [2*WIDTH-1:0] err,
  output logic [2*WIDTH-1:0] err_max
`endif
);

  localparam int PW_PROD = 2 * WIDTH;

  logic               w_stall;
  logic [WIDTH-1:0]   w_keep;
  logic [PW_PROD-1:0] w_sum, w_carry, w_p;
  logic               r_s1_valid;
  logic [PW_PROD-1:0] r_s1_sum, r_s1_carry;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  always_comb begin
    w_keep = WIDTH'(perf_mask({{(32-PW){1'b0}}, perf_start},
                              {{(32-PW){1'b0}}, perf_len}, WIDTH));
  end

  ppam_pp_reduce #(.WIDTH(WIDTH)) u_reduce (
    .a     (a),
    .b     (b),
    .keep  (w_keep),
    .sum   (w_sum),
    .carry (w_carry)
  );

  assign w_p = r_s1_sum + r_s1_carry;

  // Whole pipe advances together; a bubble in stage 1 moves on as valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_carry <= '0;
      out_valid  <= 1'b0;
      p          <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sum   <= w_sum;
        r_s1_carry <= w_carry;
      end
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        p <= w_p;
      end
    end
  end

`ifdef PPAM_ERR_EN
  logic [PW_PROD-1:0] r_s1_exact;
  logic               w_deliver;

  assign w_deliver = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_exact <= '0;
      err        <= '0;
    end else if (!w_stall) begin
      if (in_valid) begin
        r_s1_exact <= PW_PROD'(a) * PW_PROD'(b);
      end
      if (r_s1_valid) begin
        err <= r_s1_exact - w_p;
      end
    end
  end

  // A clear coinciding with a delivery restarts the maximum from that result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_max <= '0;
    end else if (err_clr) begin
      err_max <= w_deliver ? err : '0;
    end else if (w_deliver && (err > err_max)) begin
      err_max <= err;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ppam_mult_pipe.sv
// ------------------------------------------------------------------
// tb_ppam_mult_pipe: scoreboard bench for ppam_mult_pipe (PPAM_ERR_EN aware).  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_ppam_mult_pipe;

  localparam int WIDTH = 8;
  localparam int PW    = $clog2(WIDTH) + 1;
  localparam int PRODW = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [PW-1:0]    perf_start = '0;
  logic [PW-1:0]    perf_len = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PRODW-1:0] p;
`ifdef PPAM_ERR_EN
  logic             err_clr = 1'b0;
  logic [PRODW-1:0] err;
  logic [PRODW-1:0] err_max;
  logic [PRODW-1:0] m_errmax = '0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bp_mode = 0;

  typedef struct {
    logic [PRODW-1:0] p;
    logic [PRODW-1:0] err;
    int               acc_cyc;
    bit               lat_chk;
  } exp_t;

  exp_t sb[$];

  ppam_mult_pipe #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .perf_start (perf_start),
    .perf_len   (perf_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p          (p)
`ifdef PPAM_ERR_EN
    ,
    .err_clr    (err_clr),
    .err        (err),
    .err_max    (err_max)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sum of kept rows, row j kept unless start <= j < start+len.
  function automatic logic [PRODW-1:0] model_p(input int av, input int bv,
                                               input int st, input int ln);
    longint acc;
    acc = 0;
    for (int j = 0; j < WIDTH; j++) begin
      if ((((bv >> j) & 1) == 1) && !((j >= st) && (j < st + ln)))
        acc += longint'(av) << j;
    end
    return acc[PRODW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input int av, input int bv, input int st, input int ln);
    exp_t e;
    bit   done;
    done = 0;
    a = av[WIDTH-1:0];
    b = bv[WIDTH-1:0];
    perf_start = st[PW-1:0];
    perf_len = ln[PW-1:0];
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.p = model_p(av, bv, st, ln);
        e.err = PRODW'(av * bv) - e.p;
        e.acc_cyc = cyc;
        e.lat_chk = (bp_mode == 0);
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected acceptance within 200 cycles");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() > 0; n++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin : backpressure
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
`ifdef PPAM_ERR_EN
      err_clr = (bp_mode == 1) && ($urandom_range(0, 15) == 0);
`endif
    end
  end

  logic [PRODW-1:0] prev_p;
  bit               prev_stall = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_p_hold", 64'(p), 64'(prev_p));
        check("stall_valid_hold", 64'(out_valid), 64'd1);
      end
      if (out_valid && !out_ready) check("in_ready_in_stall", 64'(in_ready), 64'd0);
`ifdef PPAM_ERR_EN
      check("err_max", 64'(err_max), 64'(m_errmax));
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got p=%0d with no beat outstanding", p);
        end else begin
          e = sb.pop_front();
          check("p", 64'(p), 64'(e.p));
          if (e.lat_chk) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
`ifdef PPAM_ERR_EN
          check("err", 64'(err), 64'(e.err));
          if (err_clr) m_errmax = e.err;
          else if (e.err > m_errmax) m_errmax = e.err;
`endif
        end
      end
`ifdef PPAM_ERR_EN
      else if (err_clr) m_errmax = '0;
`endif
      prev_stall = out_valid && !out_ready;
      prev_p = p;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_p", 64'(p), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed points.
    send(200, 100, 0, 0);
    drain();
    send(255, 255, 1, 3);
    drain();
    send(255, 255, 6, 5);
    drain();
    send(255, 255, 9, 3);
    drain();
    send(255, 255, 15, 15);
    send(255, 255, 0, 15);
    send(170, 85, 7, 1);
    send(255, 255, 0, 8);
    drain();

    // Back-to-back, one result per cycle.
    for (int i = 1; i <= 20; i++) send(i, 3, 0, 0);
    drain();

    // Backpressure: three beats offered while the output is blocked.
    bp_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        send(11, 13, 0, 0);
        send(250, 251, 2, 2);
        send(99, 77, 3, 4);
      end
      begin
        repeat (5) @(posedge clk);
        bp_mode = 0;
      end
    join
    drain();

    // Randomised traffic with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send($urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 15), $urandom_range(0, 15));
    end
    bp_mode = 0;
    drain();

    // Reset with two beats in flight.
    send(123, 45, 2, 3);
    send(201, 17, 0, 0);
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_p", 64'(p), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PPAM_ERR_EN
    check("rst_err_max", 64'(err_max), 64'd0);
    m_errmax = '0;
`endif
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_idle", 64'(out_valid), 64'd0);
    send(7, 9, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
